// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone Classic master controller.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wb_master_state_t;

  localparam int WB_TIMEOUT_DEFAULT = 15;
  localparam int WB_TIMEOUT_W       = 8;

endpackage

// File: rtl/if_wishbone.sv
// Wishbone Classic shared-bus signal bundle with master and slave views.
interface if_wishbone #(
  parameter int AW = 2,
  parameter int DW = 8
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_m;
  logic [DW-1:0] data_s;
  logic          ack;

  modport master (
    output cyc, stb, we, addr, data_m,
    input  data_s, ack
  );

  modport slave (
    input  cyc, stb, we, addr, data_m,
    output data_s, ack
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating wait-state counter; expired flags the last un-acked BUS cycle.
module wb_timeout_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // The increment in this cycle would reach limit, so this is the final BUS cycle.
  assign expired = en && (count >= (limit - 1'b1));

endmodule

// File: rtl/wb_master_ctrl.sv
// Single-transfer Wishbone Classic initiator. Optional watchdog abort is
// compiled in with the WB_MASTER_TIMEOUT_EN macro.
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  if_wishbone.master    wbm
);

  wb_master_state_t state, state_nxt;

  logic          start;
  logic          finish;
  logic          abort;
  logic          expired;
  logic [AW-1:0] addr_p1;
  logic          we_p1;
  logic [DW-1:0] wdata_p1;
  logic          done_p2;
  logic          err_p2;
  logic [DW-1:0] rdata_p2;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [WB_TIMEOUT_W-1:0] TIMEOUT_LIM = WB_TIMEOUT_W'(TIMEOUT);

  wb_timeout_counter #(.W(WB_TIMEOUT_W)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .en      ((state == BUS) && !wbm.ack),
    .limit   (TIMEOUT_LIM),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          start     = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wbm.ack) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          finish    = 1'b1;
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: request capture, held stable while stb is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_p1  <= '0;
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
    end else if (start) begin
      addr_p1  <= addr;
      we_p1    <= we;
      wdata_p1 <= we ? wdata : '0;
    end
  end

  // Stage 2: completion report to the host
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_p2  <= 1'b0;
      err_p2   <= 1'b0;
      rdata_p2 <= '0;
    end else begin
      done_p2 <= finish;
      err_p2  <= abort;
      if (finish && !abort && !we_p1) begin
        rdata_p2 <= wbm.data_s;
      end
    end
  end

  assign busy       = (state == BUS);
  assign wbm.cyc    = (state == BUS);
  assign wbm.stb    = (state == BUS);
  assign wbm.we     = we_p1;
  assign wbm.addr   = addr_p1;
  assign wbm.data_m = wdata_p1;
  assign done       = done_p2;
  assign err        = err_p2;
  assign rdata      = rdata_p2;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Directed bench for wb_master_ctrl; checks either build of WB_MASTER_TIMEOUT_EN.
module tb_wb_master_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  int n_vec  = 0;
  int n_miss = 0;

  if_wishbone #(.AW(2), .DW(8)) bus ();

  wb_master_ctrl #(.AW(2), .DW(8), .TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .wbm     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n     = 1'b0;
    req         = 1'b0;
    we          = 1'b0;
    addr        = 2'h0;
    wdata       = 8'h00;
    bus.ack     = 1'b0;
    bus.data_s  = 8'h00;
    repeat (3) tick();

    chk("rst_stb",    32'(bus.stb),    32'h0);
    chk("rst_cyc",    32'(bus.cyc),    32'h0);
    chk("rst_we",     32'(bus.we),     32'h0);
    chk("rst_addr",   32'(bus.addr),   32'h0);
    chk("rst_data_m", 32'(bus.data_m), 32'h0);
    chk("rst_busy",   32'(busy),       32'h0);
    chk("rst_done",   32'(done),       32'h0);
    chk("rst_err",    32'(err),        32'h0);
    chk("rst_rdata",  32'(rdata),      32'h0);
    reset_n = 1'b1;
    tick();

    // Single write, acked in the first BUS cycle
    req = 1'b1; we = 1'b1; addr = 2'h1; wdata = 8'hA5; bus.ack = 1'b1;
    tick();
    chk("wr_stb",    32'(bus.stb),    32'h1);
    chk("wr_cyc",    32'(bus.cyc),    32'h1);
    chk("wr_addr",   32'(bus.addr),   32'h1);
    chk("wr_data_m", 32'(bus.data_m), 32'hA5);
    chk("wr_we",     32'(bus.we),     32'h1);
    chk("wr_busy",   32'(busy),       32'h1);
    chk("wr_done0",  32'(done),       32'h0);
    req = 1'b0;
    tick();
    chk("wr_stb_end", 32'(bus.stb), 32'h0);
    chk("wr_done",    32'(done),    32'h1);
    chk("wr_err",     32'(err),     32'h0);
    chk("wr_rdata",   32'(rdata),   32'h0);
    bus.ack = 1'b0;
    tick();
    chk("wr_done_pulse", 32'(done), 32'h0);

    // Read with two wait states; write data must be masked on reads
    req = 1'b1; we = 1'b0; addr = 2'h0; wdata = 8'hFF; bus.data_s = 8'h3C;
    tick();
    chk("rd_stb1",    32'(bus.stb),    32'h1);
    chk("rd_we",      32'(bus.we),     32'h0);
    chk("rd_addr",    32'(bus.addr),   32'h0);
    chk("rd_data_m",  32'(bus.data_m), 32'h0);
    req = 1'b0;
    tick();
    chk("rd_stb2", 32'(bus.stb), 32'h1);
    tick();
    chk("rd_stb3", 32'(bus.stb), 32'h1);
    chk("rd_done_wait", 32'(done), 32'h0);
    bus.ack = 1'b1;
    tick();
    chk("rd_stb_end", 32'(bus.stb), 32'h0);
    chk("rd_done",    32'(done),    32'h1);
    chk("rd_err",     32'(err),     32'h0);
    chk("rd_rdata",   32'(rdata),   32'h3C);
    bus.ack = 1'b0; bus.data_s = 8'h00;
    repeat (10) tick();
    chk("rd_rdata_hold", 32'(rdata), 32'h3C);
    chk("rd_idle_done",  32'(done),  32'h0);

    // Ack held high with req held high: alternating BUS/IDLE
    req = 1'b1; we = 1'b1; addr = 2'h2; wdata = 8'h11; bus.ack = 1'b1;
    tick();
    chk("ha_stb1",  32'(bus.stb), 32'h1);
    chk("ha_done1", 32'(done),    32'h0);
    tick();
    chk("ha_stb2",  32'(bus.stb), 32'h0);
    chk("ha_done2", 32'(done),    32'h1);
    tick();
    chk("ha_stb3",  32'(bus.stb), 32'h1);
    chk("ha_done3", 32'(done),    32'h0);
    tick();
    chk("ha_stb4",  32'(bus.stb), 32'h0);
    chk("ha_done4", 32'(done),    32'h1);
    chk("ha_rdata", 32'(rdata),   32'h3C);
    req = 1'b0;
    tick();
    chk("ha_stb5",  32'(bus.stb), 32'h0);
    chk("ha_done5", 32'(done),    32'h0);
    bus.ack = 1'b0;

    // A second req during BUS is ignored
    req = 1'b1; we = 1'b1; addr = 2'h2; wdata = 8'h5A;
    tick();
    chk("rb_addr1", 32'(bus.addr), 32'h2);
    addr = 2'h3; wdata = 8'hEE;
    tick();
    chk("rb_addr2",   32'(bus.addr),   32'h2);
    chk("rb_data_m2", 32'(bus.data_m), 32'h5A);
    req = 1'b0; bus.ack = 1'b1;
    tick();
    chk("rb_done", 32'(done), 32'h1);
    chk("rb_addr3", 32'(bus.addr), 32'h2);
    bus.ack = 1'b0;
    tick();
    chk("rb_no_retry", 32'(bus.stb), 32'h0);

    // No ack: watchdog abort, or indefinite wait without it
    req = 1'b1; we = 1'b0; addr = 2'h1; bus.data_s = 8'h77;
    tick();
    req = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    chk("to_stb1", 32'(bus.stb), 32'h1);
    tick();
    chk("to_stb2", 32'(bus.stb), 32'h1);
    tick();
    chk("to_stb3", 32'(bus.stb), 32'h1);
    tick();
    chk("to_stb4", 32'(bus.stb), 32'h1);
    chk("to_done_wait", 32'(done), 32'h0);
    tick();
    chk("to_stb_end", 32'(bus.stb), 32'h0);
    chk("to_done",    32'(done),    32'h1);
    chk("to_err",     32'(err),     32'h1);
    chk("to_rdata",   32'(rdata),   32'h3C);
    tick();
    chk("to_err_pulse", 32'(err), 32'h0);
    req = 1'b1; we = 1'b1; addr = 2'h1; wdata = 8'h99;
    tick();
    req = 1'b0;
`else
    repeat (100) tick();
    chk("nto_stb",  32'(bus.stb), 32'h1);
    chk("nto_done", 32'(done),    32'h0);
    chk("nto_err",  32'(err),     32'h0);
`endif

    // Asynchronous reset in the middle of a BUS phase
    chk("ar_busy_pre", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_stb",    32'(bus.stb),    32'h0);
    chk("ar_cyc",    32'(bus.cyc),    32'h0);
    chk("ar_busy",   32'(busy),       32'h0);
    chk("ar_addr",   32'(bus.addr),   32'h0);
    chk("ar_we",     32'(bus.we),     32'h0);
    chk("ar_data_m", 32'(bus.data_m), 32'h0);
    chk("ar_rdata",  32'(rdata),      32'h0);
    chk("ar_done",   32'(done),       32'h0);
    chk("ar_err",    32'(err),        32'h0);
    bus.ack = 1'b1;
    tick();
    tick();
    bus.ack = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("ar_no_done", 32'(done), 32'h0);

    // Normal transfer after reset recovery
    req = 1'b1; we = 1'b1; addr = 2'h3; wdata = 8'hC3; bus.ack = 1'b1;
    tick();
    chk("pr_stb",    32'(bus.stb),    32'h1);
    chk("pr_addr",   32'(bus.addr),   32'h3);
    chk("pr_data_m", 32'(bus.data_m), 32'hC3);
    req = 1'b0;
    tick();
    chk("pr_done", 32'(done), 32'h1);
    chk("pr_err",  32'(err),  32'h0);
    bus.ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
